ic_bram_cpu_bus_bridge: RTL
===========================

IC_BRAM_CPU_BUS_BRIDGE -- requirements
Module: ic_bram_cpu_bus_bridge

Interface
REQ-001 Parameter: POSTED_WRITES, 0, 1 = writes complete to the BRAM side at grant, and the bus response is drained in the background.
REQ-002 Ports (name  direction  width  meaning):
- g_clk  in  1  sole clock; all state on its rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- bram_cen  in  1  BRAM-side access request.
- bram_addr  in  32  access address.
- bram_wdata  in  32  write data.
- bram_wstrb  in  4  write strobe; 4'b0000 = read.
- bram_stall  out  1  access not yet accepted.
- bram_rdata  out  32  read data.
- bram_error  out  1  access error, valid with bram_rdata.
- enable  in  1  permits starting new transactions.
- mem_req  out  1  bus request.
- mem_gnt  in  1  request accepted.
- mem_wen  out  1  write enable.
- mem_strb  out  4  write strobe.
- mem_wdata  out  32  write data.
- mem_addr  out  32  address.
- mem_recv  in  1  response valid.
- mem_ack  out  1  response accepted.
- mem_error  in  1  response error.
- mem_rdata  in  32  response data.
- posted_err  out  1  sticky posted-write error.
- err_clr  in  1  clears posted_err.

Function
REQ-003 The block SHALL act as bus initiator for a single BRAM-style master and SHALL have at most one bus transaction outstanding.
REQ-004 The FSM SHALL have the states IDLE, REQ, RSP and DONE; encodings are defined in the shared package.
REQ-005 IDLE->REQ SHALL occur when bram_cen && enable && !drain; addr, wdata and wstrb are captured into registers and mem_wen = |wstrb.
REQ-006 In REQ, mem_req SHALL be 1 and mem_addr/wdata/strb/wen SHALL be driven from the captured registers, held stable until mem_gnt.
REQ-007 On REQ && mem_gnt: if POSTED_WRITES && write, the next state SHALL be DONE with drain set; otherwise it SHALL be RSP.
REQ-008 mem_ack SHALL be 1 in RSP or while drain=1, and 0 otherwise.
REQ-009 On RSP && mem_recv, the block SHALL capture mem_rdata and mem_error into rdata_q/err_q and go to DONE.
REQ-010 DONE->IDLE SHALL be unconditional.
REQ-011 bram_stall SHALL equal bram_cen && (state != DONE); the access is accepted in DONE.
REQ-012 bram_rdata/bram_error SHALL be driven from rdata_q/err_q, valid from the cycle after acceptance and held until the next non-posted response.
REQ-013 For a posted write, err_q SHALL be 0 and rdata_q SHALL be unchanged.
REQ-014 On drain && mem_recv, the block SHALL clear drain, and SHALL set posted_err if mem_error.
REQ-015 When err_clr and a set event occur in the same cycle, the set SHALL win.
REQ-016 mem_recv is never asserted in the same cycle as its grant; mem_recv outside RSP or drain SHALL be ignored.
REQ-017 While enable=0, IDLE SHALL hold and bram_stall SHALL follow bram_cen; a transaction already past IDLE SHALL complete regardless of enable.
REQ-018 If bram_cen drops while in REQ or RSP, the bus transaction SHALL still complete, and the DONE cycle SHALL not be observed as an acceptance.
REQ-019 Minimum read latency SHALL be 4 cycles from cen to data (IDLE, REQ with gnt, RSP with recv, DONE), with data valid in cycle 4.

Reset
REQ-020 On g_resetn low, the block SHALL asynchronously set: state = IDLE, drain = 0, rdata_q = 0, err_q = 0, posted_err = 0, capture registers = 0, mem_req = 0, mem_ack = 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction without further handshakes; the bus side is reset by the same g_resetn.

Structure
REQ-022 The FSM state typedef/localparams and the strobe-width constant SHALL live in the shared interconnect package.
REQ-023 The block SHALL be a single module with no sub-modules.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Read 0x1000, gnt immediate, recv 1 cycle later with data 0xDEADBEEF -> stall high 3 cycles, bram_rdata = 0xDEADBEEF, bram_error = 0 next cycle.
- Write 0x2000, wdata 0x12345678, strb 4'b0011, gnt delayed 3 cycles -> mem_req held 4 cycles with stable fields, mem_wen = 1.
- POSTED_WRITES=1 write, then a read issued in DONE's next cycle, recv of the write delayed 5 cycles -> read mem_req not raised until drain clears.
- Posted write with mem_error = 1 -> posted_err = 1; err_clr together with a new error -> stays 1; err_clr alone -> 0.
- Read response with mem_error = 1, data 0xFFFFFFFF -> bram_error = 1 alongside data.
- g_resetn pulsed during RSP -> all outputs at reset values immediately; a later stray mem_recv is ignored.

Source files
------------

// File: rtl/ic_bram_cpu_bus_bridge_pkg.sv
// ----------------------------------------------------------------------------
// ic_bram_cpu_bus_bridge_pkg
// Shared interconnect definitions for the BRAM-to-bus bridge: bus widths,
// write-strobe width and the bridge FSM state encoding.
// ----------------------------------------------------------------------------
package ic_bram_cpu_bus_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/ic_bram_cpu_bus_bridge_if.sv
// ----------------------------------------------------------------------------
// ic_bram_cpu_bus_bridge_if
// Request/response bus between the bridge (master) and the interconnect
// (slave).
//   mem_req/mem_gnt           request handshake, fields held until grant
//   mem_wen/strb/wdata/addr   request fields
//   mem_recv/mem_ack          response handshake
//   mem_error/mem_rdata       response payload
// ----------------------------------------------------------------------------
interface ic_bram_cpu_bus_bridge_if;
    import ic_bram_cpu_bus_bridge_pkg::*;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_wen;
    logic [STRB_W-1:0] mem_strb;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_recv;
    logic              mem_ack;
    logic              mem_error;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );

endinterface

// File: rtl/ic_bram_cpu_bus_bridge.sv
// ----------------------------------------------------------------------------
// ic_bram_cpu_bus_bridge
// Turns single BRAM-style accesses (cen/addr/wdata/wstrb, stall) into one
// outstanding request/response bus transaction at a time. With
// POSTED_WRITES=1 writes are accepted at grant and their response is drained
// in the background; errors on drained responses set the sticky posted_err.
//
// Ports
//   g_clk, g_resetn          clock, async active-low reset
//   bram_cen/addr/wdata/wstrb  BRAM-side access (wstrb==0 is a read)
//   bram_stall               access not yet accepted
//   bram_rdata/bram_error    response of the last non-posted access
//   enable                   permits starting new transactions
//   bus                      bus master modport
//   posted_err, err_clr      sticky posted-write error and its clear
//
// State table
//   state   | meaning
//   ST_IDLE | waiting for an access; also parked while a posted write drains
//   ST_REQ  | mem_req raised with captured fields, waiting for mem_gnt
//   ST_RSP  | granted, waiting for mem_recv
//   ST_DONE | access accepted (stall low) for one cycle
// ----------------------------------------------------------------------------
module ic_bram_cpu_bus_bridge
    import ic_bram_cpu_bus_bridge_pkg::*;
#(
    parameter bit POSTED_WRITES = 1'b0
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     bram_cen,
    input  logic [ADDR_W-1:0]        bram_addr,
    input  logic [DATA_W-1:0]        bram_wdata,
    input  logic [STRB_W-1:0]        bram_wstrb,
    output logic                     bram_stall,
    output logic [DATA_W-1:0]        bram_rdata,
    output logic                     bram_error,
    input  logic                     enable,
    ic_bram_cpu_bus_bridge_if.master bus,
    output logic                     posted_err,
    input  logic                     err_clr
);

    bridge_state_e     state_q, state_d;
    logic              drain_q;
    logic              cen_lost_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              wen_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              posted_err_q;

    logic start, grant, posted_grant, rsp_done, drain_done;

    assign start        = (state_q == ST_IDLE) && bram_cen && enable && !drain_q;
    assign grant        = (state_q == ST_REQ) && bus.mem_gnt;
    assign posted_grant = grant && POSTED_WRITES && wen_q;
    assign rsp_done     = (state_q == ST_RSP) && bus.mem_recv;
    assign drain_done   = drain_q && bus.mem_recv;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (grant) state_d = posted_grant ? ST_DONE : ST_RSP;
            ST_RSP:  if (bus.mem_recv) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // If the master let go of cen while the transaction was in flight, a
    // cen seen in DONE belongs to a new access and must not be acknowledged.
    always_comb begin
        bram_stall    = bram_cen && ((state_q != ST_DONE) || cen_lost_q);
        bus.mem_req   = (state_q == ST_REQ);
        bus.mem_ack   = (state_q == ST_RSP) || drain_q;
        bus.mem_wen   = wen_q;
        bus.mem_strb  = strb_q;
        bus.mem_wdata = wdata_q;
        bus.mem_addr  = addr_q;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            drain_q      <= 1'b0;
            cen_lost_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            wen_q        <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            posted_err_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= bram_addr;
                wdata_q <= bram_wdata;
                strb_q  <= bram_wstrb;
                wen_q   <= |bram_wstrb;
            end

            if (start) begin
                cen_lost_q <= 1'b0;
            end else if (((state_q == ST_REQ) || (state_q == ST_RSP)) && !bram_cen) begin
                cen_lost_q <= 1'b1;
            end

            if (posted_grant) begin
                drain_q <= 1'b1;
            end else if (drain_done) begin
                drain_q <= 1'b0;
            end

            // Posted writes report no error and leave the last read data alone.
            if (rsp_done) begin
                rdata_q <= bus.mem_rdata;
                err_q   <= bus.mem_error;
            end else if (posted_grant) begin
                err_q   <= 1'b0;
            end

            // Set has priority over clear.
            if (drain_done && bus.mem_error) begin
                posted_err_q <= 1'b1;
            end else if (err_clr) begin
                posted_err_q <= 1'b0;
            end
        end
    end

    assign bram_rdata = rdata_q;
    assign bram_error = err_q;
    assign posted_err = posted_err_q;

endmodule
